// File: rtl/axi_rr_arbiter.sv
// Purpose: N-master to 1-slave AXI4 arbiter with independent round-robin read and write paths.
// Latency: 1-cycle grant (IDLE -> AR/AW); payload and handshakes are combinational passthrough once granted.
// Backpressure: only the owner sees slave ready/valid; all other masters see 0 until the owning burst completes.
//
// Ports:
//   i_clock, i_reset            : clock and synchronous active-high reset
//   i_m_ar*/o_m_arready         : per-master AR channel, master k in slice k
//   o_m_r*/i_m_rready           : per-master R channel
//   i_m_aw*/o_m_awready         : per-master AW channel
//   i_m_w*/o_m_wready           : per-master W channel
//   o_m_b*/i_m_bready           : per-master B channel
//   o_ar*, i_r*, o_aw*, o_w*, i_b* and matching ready/valid : slave-side AXI4 port
//   o_rd_grant, o_wr_grant      : one-hot owner of each path, 0 when idle
module axi_rr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    // master-side read
    input  logic [NUM_M*ADDR_W-1:0]   i_m_araddr,
    input  logic [NUM_M*ID_W-1:0]     i_m_arid,
    input  logic [NUM_M*8-1:0]        i_m_arlen,
    input  logic [NUM_M*3-1:0]        i_m_arsize,
    input  logic [NUM_M*2-1:0]        i_m_arburst,
    input  logic [NUM_M-1:0]          i_m_arvalid,
    output logic [NUM_M-1:0]          o_m_arready,
    output logic [NUM_M*DATA_W-1:0]   o_m_rdata,
    output logic [NUM_M*2-1:0]        o_m_rresp,
    output logic [NUM_M*ID_W-1:0]     o_m_rid,
    output logic [NUM_M-1:0]          o_m_rvalid,
    output logic [NUM_M-1:0]          o_m_rlast,
    input  logic [NUM_M-1:0]          i_m_rready,
    // master-side write
    input  logic [NUM_M*ADDR_W-1:0]   i_m_awaddr,
    input  logic [NUM_M*ID_W-1:0]     i_m_awid,
    input  logic [NUM_M*8-1:0]        i_m_awlen,
    input  logic [NUM_M*3-1:0]        i_m_awsize,
    input  logic [NUM_M*2-1:0]        i_m_awburst,
    input  logic [NUM_M-1:0]          i_m_awvalid,
    output logic [NUM_M-1:0]          o_m_awready,
    input  logic [NUM_M*DATA_W-1:0]   i_m_wdata,
    input  logic [NUM_M*DATA_W/8-1:0] i_m_wstrb,
    input  logic [NUM_M-1:0]          i_m_wvalid,
    input  logic [NUM_M-1:0]          i_m_wlast,
    output logic [NUM_M-1:0]          o_m_wready,
    output logic [NUM_M*2-1:0]        o_m_bresp,
    output logic [NUM_M*ID_W-1:0]     o_m_bid,
    output logic [NUM_M-1:0]          o_m_bvalid,
    input  logic [NUM_M-1:0]          i_m_bready,
    // slave-side read
    output logic [ADDR_W-1:0]         o_araddr,
    output logic [ID_W-1:0]           o_arid,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [DATA_W-1:0]         i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic [ID_W-1:0]           i_rid,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    // slave-side write
    output logic [ADDR_W-1:0]         o_awaddr,
    output logic [ID_W-1:0]           o_awid,
    output logic [7:0]                o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    output logic [DATA_W-1:0]         o_wdata,
    output logic [DATA_W/8-1:0]       o_wstrb,
    output logic                      o_wlast,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    input  logic [1:0]                i_bresp,
    input  logic [ID_W-1:0]           i_bid,
    input  logic                      i_bvalid,
    output logic                      o_bready,
    // grant status
    output logic [NUM_M-1:0]          o_rd_grant,
    output logic [NUM_M-1:0]          o_wr_grant
);
    localparam int PW = $clog2(NUM_M);
    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_t;

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [NUM_M-1:0] req, input logic [PW-1:0] ptr);
        logic [PW-1:0] j;
        logic [PW-1:0] idx;
        logic          found;
        j     = ptr;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
            j = (j == PW'(NUM_M - 1)) ? '0 : j + 1'b1;
        end
        return {found, idx};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_M - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NUM_M-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_M-1:0] oh;
        for (int k = 0; k < NUM_M; k++) oh[k] = (idx == PW'(k));
        return oh;
    endfunction

    rd_state_t        rd_state_q, rd_state_d;
    logic [NUM_M-1:0] rd_grant_q, rd_grant_d;
    logic [PW-1:0]    rd_idx_q, rd_idx_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      rd_pick;

    wr_state_t        wr_state_q, wr_state_d;
    logic [NUM_M-1:0] wr_grant_q, wr_grant_d;
    logic [PW-1:0]    wr_idx_q, wr_idx_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      wr_pick;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rd_state_q <= RD_IDLE;
            rd_grant_q <= '0;
            rd_idx_q   <= '0;
            rd_ptr_q   <= '0;
            wr_state_q <= WR_IDLE;
            wr_grant_q <= '0;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_idx_q   <= rd_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_idx_q   <= wr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Read FSM. The grant is cleared on the way back to IDLE so that the
    // exported grant and every routed output are zero while idle.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_idx_d   = rd_idx_q;
        rd_ptr_d   = rd_ptr_q;
        rd_pick    = rr_pick(i_m_arvalid, rd_ptr_q);
        case (rd_state_q)
            RD_IDLE: if (rd_pick[PW]) begin
                rd_state_d = RD_AR;
                rd_idx_d   = rd_pick[PW-1:0];
                rd_grant_d = onehot(rd_pick[PW-1:0]);
            end
            RD_AR: if (o_arvalid && i_arready) rd_state_d = RD_R;
            RD_R: if (i_rvalid && o_rready && i_rlast) begin
                rd_state_d = RD_IDLE;
                rd_grant_d = '0;
                rd_ptr_d   = ptr_inc(rd_idx_q);
            end
            default: begin
                rd_state_d = RD_IDLE;
                rd_grant_d = '0;
            end
        endcase
    end

    // Write FSM; the pointer only advances once the response has been accepted.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_idx_d   = wr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        wr_pick    = rr_pick(i_m_awvalid, wr_ptr_q);
        case (wr_state_q)
            WR_IDLE: if (wr_pick[PW]) begin
                wr_state_d = WR_AW;
                wr_idx_d   = wr_pick[PW-1:0];
                wr_grant_d = onehot(wr_pick[PW-1:0]);
            end
            WR_AW: if (o_awvalid && i_awready) wr_state_d = WR_W;
            WR_W:  if (o_wvalid && i_wready && o_wlast) wr_state_d = WR_B;
            WR_B: if (i_bvalid && o_bready) begin
                wr_state_d = WR_IDLE;
                wr_grant_d = '0;
                wr_ptr_d   = ptr_inc(wr_idx_q);
            end
            default: begin
                wr_state_d = WR_IDLE;
                wr_grant_d = '0;
            end
        endcase
    end

    // Read routing: everything is gated by the registered grant and state.
    always_comb begin
        o_m_arready = '0;
        o_m_rdata   = '0;
        o_m_rresp   = '0;
        o_m_rid     = '0;
        o_m_rvalid  = '0;
        o_m_rlast   = '0;
        o_araddr    = '0;
        o_arid      = '0;
        o_arlen     = '0;
        o_arsize    = '0;
        o_arburst   = '0;
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (rd_grant_q[k] && rd_state_q == RD_AR) begin
                o_araddr       = i_m_araddr[k*ADDR_W +: ADDR_W];
                o_arid         = i_m_arid[k*ID_W +: ID_W];
                o_arlen        = i_m_arlen[k*8 +: 8];
                o_arsize       = i_m_arsize[k*3 +: 3];
                o_arburst      = i_m_arburst[k*2 +: 2];
                o_arvalid      = i_m_arvalid[k];
                o_m_arready[k] = i_arready;
            end
            if (rd_grant_q[k] && rd_state_q == RD_R) begin
                o_m_rdata[k*DATA_W +: DATA_W] = i_rdata;
                o_m_rresp[k*2 +: 2]           = i_rresp;
                o_m_rid[k*ID_W +: ID_W]       = i_rid;
                o_m_rvalid[k]                 = i_rvalid;
                o_m_rlast[k]                  = i_rlast;
                o_rready                      = i_m_rready[k];
            end
        end
    end

    // Write routing: W is only opened in the W state, so early W data waits.
    always_comb begin
        o_m_awready = '0;
        o_m_wready  = '0;
        o_m_bresp   = '0;
        o_m_bid     = '0;
        o_m_bvalid  = '0;
        o_awaddr    = '0;
        o_awid      = '0;
        o_awlen     = '0;
        o_awsize    = '0;
        o_awburst   = '0;
        o_awvalid   = 1'b0;
        o_wdata     = '0;
        o_wstrb     = '0;
        o_wlast     = 1'b0;
        o_wvalid    = 1'b0;
        o_bready    = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (wr_grant_q[k] && wr_state_q == WR_AW) begin
                o_awaddr       = i_m_awaddr[k*ADDR_W +: ADDR_W];
                o_awid         = i_m_awid[k*ID_W +: ID_W];
                o_awlen        = i_m_awlen[k*8 +: 8];
                o_awsize       = i_m_awsize[k*3 +: 3];
                o_awburst      = i_m_awburst[k*2 +: 2];
                o_awvalid      = i_m_awvalid[k];
                o_m_awready[k] = i_awready;
            end
            if (wr_grant_q[k] && wr_state_q == WR_W) begin
                o_wdata       = i_m_wdata[k*DATA_W +: DATA_W];
                o_wstrb       = i_m_wstrb[k*SW +: SW];
                o_wlast       = i_m_wlast[k];
                o_wvalid      = i_m_wvalid[k];
                o_m_wready[k] = i_wready;
            end
            if (wr_grant_q[k] && wr_state_q == WR_B) begin
                o_m_bresp[k*2 +: 2]     = i_bresp;
                o_m_bid[k*ID_W +: ID_W] = i_bid;
                o_m_bvalid[k]           = i_bvalid;
                o_bready                = i_m_bready[k];
            end
        end
    end

    assign o_rd_grant = rd_grant_q;
    assign o_wr_grant = wr_grant_q;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
module tb_axi_rr_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    always #5 i_clock = ~i_clock;

    logic [NM*AW-1:0]   i_m_araddr, i_m_awaddr;
    logic [NM*IW-1:0]   i_m_arid, i_m_awid;
    logic [NM*8-1:0]    i_m_arlen, i_m_awlen;
    logic [NM*3-1:0]    i_m_arsize, i_m_awsize;
    logic [NM*2-1:0]    i_m_arburst, i_m_awburst;
    logic [NM-1:0]      i_m_arvalid, o_m_arready, o_m_rvalid, o_m_rlast, i_m_rready;
    logic [NM*DW-1:0]   o_m_rdata, i_m_wdata;
    logic [NM*2-1:0]    o_m_rresp, o_m_bresp;
    logic [NM*IW-1:0]   o_m_rid, o_m_bid;
    logic [NM-1:0]      i_m_awvalid, o_m_awready, i_m_wvalid, i_m_wlast, o_m_wready;
    logic [NM*DW/8-1:0] i_m_wstrb;
    logic [NM-1:0]      o_m_bvalid, i_m_bready;
    logic [AW-1:0]      o_araddr, o_awaddr;
    logic [IW-1:0]      o_arid, o_awid, i_rid, i_bid;
    logic [7:0]         o_arlen, o_awlen;
    logic [2:0]         o_arsize, o_awsize;
    logic [1:0]         o_arburst, o_awburst, i_rresp, i_bresp;
    logic               o_arvalid, i_arready, i_rlast, i_rvalid, o_rready;
    logic               o_awvalid, i_awready, o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
    logic [DW-1:0]      i_rdata, o_wdata;
    logic [DW/8-1:0]    o_wstrb;
    logic [NM-1:0]      o_rd_grant, o_wr_grant;

    int total = 0;
    int bad   = 0;

    axi_rr_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_m_araddr(i_m_araddr), .i_m_arid(i_m_arid), .i_m_arlen(i_m_arlen),
        .i_m_arsize(i_m_arsize), .i_m_arburst(i_m_arburst), .i_m_arvalid(i_m_arvalid),
        .o_m_arready(o_m_arready), .o_m_rdata(o_m_rdata), .o_m_rresp(o_m_rresp),
        .o_m_rid(o_m_rid), .o_m_rvalid(o_m_rvalid), .o_m_rlast(o_m_rlast), .i_m_rready(i_m_rready),
        .i_m_awaddr(i_m_awaddr), .i_m_awid(i_m_awid), .i_m_awlen(i_m_awlen),
        .i_m_awsize(i_m_awsize), .i_m_awburst(i_m_awburst), .i_m_awvalid(i_m_awvalid),
        .o_m_awready(o_m_awready), .i_m_wdata(i_m_wdata), .i_m_wstrb(i_m_wstrb),
        .i_m_wvalid(i_m_wvalid), .i_m_wlast(i_m_wlast), .o_m_wready(o_m_wready),
        .o_m_bresp(o_m_bresp), .o_m_bid(o_m_bid), .o_m_bvalid(o_m_bvalid), .i_m_bready(i_m_bready),
        .o_araddr(o_araddr), .o_arid(o_arid), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rid(i_rid), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awid(o_awid), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready), .i_bresp(i_bresp), .i_bid(i_bid), .i_bvalid(i_bvalid),
        .o_bready(o_bready), .o_rd_grant(o_rd_grant), .o_wr_grant(o_wr_grant)
    );

    task automatic tick;
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_inputs;
        i_m_araddr = '0; i_m_arid = '0; i_m_arlen = '0; i_m_arsize = '0; i_m_arburst = '0;
        i_m_arvalid = '0; i_m_rready = '1;
        i_m_awaddr = '0; i_m_awid = '0; i_m_awlen = '0; i_m_awsize = '0; i_m_awburst = '0;
        i_m_awvalid = '0; i_m_wdata = '0; i_m_wstrb = '0; i_m_wvalid = '0; i_m_wlast = '0;
        i_m_bready = '1;
        i_arready = 1'b0; i_rdata = '0; i_rresp = '0; i_rid = '0; i_rlast = 1'b0; i_rvalid = 1'b0;
        i_awready = 1'b0; i_wready = 1'b0; i_bresp = '0; i_bid = '0; i_bvalid = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    // Single-beat read by the masters in mask, starting from an idle read path.
    task automatic run_single_read(input logic [NM-1:0] mask);
        i_m_arvalid = mask;
        i_m_arlen   = '0;
        i_arready   = 1'b1;
        tick();
        tick();
        i_m_arvalid = '0;
        i_rvalid    = 1'b1;
        i_rlast     = 1'b1;
        tick();
        i_rvalid  = 1'b0;
        i_rlast   = 1'b0;
        i_arready = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        i_reset     = 1'b1;
        i_m_arvalid = 3'b001;
        i_m_awvalid = 3'b010;
        i_arready   = 1'b1;
        tick();
        tick();
        total++; if (o_rd_grant !== 3'b000) begin bad++; $display("FAIL reset_rd_grant: got %b want 000", o_rd_grant); end
        total++; if (o_wr_grant !== 3'b000) begin bad++; $display("FAIL reset_wr_grant: got %b want 000", o_wr_grant); end
        total++; if (o_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b want 0", o_arvalid); end
        total++; if (o_awvalid !== 1'b0) begin bad++; $display("FAIL reset_awvalid: got %b want 0", o_awvalid); end
        total++; if (o_m_arready !== 3'b000) begin bad++; $display("FAIL reset_m_arready: got %b want 000", o_m_arready); end
        i_reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_single_read;
        apply_reset();
        i_m_araddr[31:0] = 32'h8000_0000;
        i_m_arid[3:0]    = 4'h5;
        i_m_arvalid      = 3'b001;
        i_arready        = 1'b1;
        #1;
        total++; if (o_arvalid !== 1'b0) begin bad++; $display("FAIL sr_idle_arvalid: got %b want 0", o_arvalid); end
        tick();
        total++; if (o_arvalid !== 1'b1) begin bad++; $display("FAIL sr_arvalid: got %b want 1", o_arvalid); end
        total++; if (o_araddr !== 32'h8000_0000) begin bad++; $display("FAIL sr_araddr: got %h want 80000000", o_araddr); end
        total++; if (o_arid !== 4'h5) begin bad++; $display("FAIL sr_arid: got %h want 5", o_arid); end
        total++; if (o_rd_grant !== 3'b001) begin bad++; $display("FAIL sr_grant: got %b want 001", o_rd_grant); end
        total++; if (o_m_arready !== 3'b001) begin bad++; $display("FAIL sr_m_arready: got %b want 001", o_m_arready); end
        tick();
        i_m_arvalid = '0;
        i_arready   = 1'b0;
        i_rdata     = 32'hDEAD_BEEF;
        i_rid       = 4'h5;
        i_rlast     = 1'b1;
        i_rvalid    = 1'b1;
        #1;
        total++; if (o_m_rvalid !== 3'b001) begin bad++; $display("FAIL sr_m_rvalid: got %b want 001", o_m_rvalid); end
        total++; if (o_m_rdata !== {64'h0, 32'hDEAD_BEEF}) begin bad++; $display("FAIL sr_m_rdata: got %h want 0000000000000000deadbeef", o_m_rdata); end
        total++; if (o_m_rid !== 12'h005) begin bad++; $display("FAIL sr_m_rid: got %h want 005", o_m_rid); end
        total++; if (o_rready !== 1'b1) begin bad++; $display("FAIL sr_rready: got %b want 1", o_rready); end
        tick();
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        #1;
        total++; if (o_rd_grant !== 3'b000) begin bad++; $display("FAIL sr_grant_end: got %b want 000", o_rd_grant); end
        total++; if (o_m_rvalid !== 3'b000) begin bad++; $display("FAIL sr_rvalid_end: got %b want 000", o_m_rvalid); end
    endtask

    task automatic test_rr_order;
        logic [NM-1:0] got_g [5];
        logic [31:0]   got_a [5];
        logic [NM-1:0] exp_g [5];
        logic [31:0]   exp_a [5];
        int n;
        n     = 0;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_a = '{32'h100, 32'h200, 32'h300, 32'h100, 32'h200};
        apply_reset();
        i_m_araddr  = {32'h300, 32'h200, 32'h100};
        i_m_arvalid = 3'b111;
        i_arready   = 1'b1;
        i_rvalid    = 1'b1;
        i_rlast     = 1'b1;
        for (int c = 0; c < 60 && n < 5; c++) begin
            tick();
            if (o_arvalid) begin
                got_g[n] = o_rd_grant;
                got_a[n] = o_araddr;
                n++;
            end
        end
        total++; if (n !== 5) begin bad++; $display("FAIL rr_grant_count: got %0d want 5 within budget", n); end
        for (int i = 0; i < n; i++) begin
            total++; if (got_g[i] !== exp_g[i]) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", i, got_g[i], exp_g[i]); end
            total++; if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL rr_addr_%0d: got %h want %h", i, got_a[i], exp_a[i]); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_burst;
        apply_reset();
        i_m_araddr  = {32'h0, 32'h40, 32'h0};
        i_m_arlen   = {8'd0, 8'd3, 8'd0};
        i_m_arvalid = 3'b010;
        i_arready   = 1'b1;
        tick();
        total++; if (o_rd_grant !== 3'b010) begin bad++; $display("FAIL bu_grant: got %b want 010", o_rd_grant); end
        total++; if (o_arlen !== 8'd3) begin bad++; $display("FAIL bu_arlen: got %0d want 3", o_arlen); end
        total++; if (o_araddr !== 32'h40) begin bad++; $display("FAIL bu_araddr: got %h want 40", o_araddr); end
        tick();
        i_m_arvalid      = 3'b001;
        i_m_araddr[31:0] = 32'h80;
        for (int b = 0; b < 4; b++) begin
            i_rvalid = 1'b1;
            i_rdata  = 32'hA0 + 32'(b);
            i_rlast  = (b == 3);
            #1;
            total++; if (o_m_rvalid !== 3'b010) begin bad++; $display("FAIL bu_rvalid_%0d: got %b want 010", b, o_m_rvalid); end
            total++; if (o_m_rdata[63:32] !== 32'hA0 + 32'(b)) begin bad++; $display("FAIL bu_rdata_%0d: got %h want %h", b, o_m_rdata[63:32], 32'hA0 + 32'(b)); end
            total++; if (o_m_rlast !== ((b == 3) ? 3'b010 : 3'b000)) begin bad++; $display("FAIL bu_rlast_%0d: got %b", b, o_m_rlast); end
            total++; if (o_arvalid !== 1'b0) begin bad++; $display("FAIL bu_holdoff_%0d: got arvalid %b want 0", b, o_arvalid); end
            tick();
        end
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        #1;
        total++; if (o_rd_grant !== 3'b000) begin bad++; $display("FAIL bu_idle_grant: got %b want 000", o_rd_grant); end
        tick();
        total++; if (o_rd_grant !== 3'b001) begin bad++; $display("FAIL bu_next_grant: got %b want 001", o_rd_grant); end
        total++; if (o_araddr !== 32'h80) begin bad++; $display("FAIL bu_next_addr: got %h want 80", o_araddr); end
        tick();
        i_m_arvalid = '0;
        i_rvalid    = 1'b1;
        i_rlast     = 1'b1;
        tick();
        clear_inputs();
        #1;
        total++; if (o_rd_grant !== 3'b000) begin bad++; $display("FAIL bu_end_grant: got %b want 000", o_rd_grant); end
    endtask

    task automatic test_concurrent_rw;
        apply_reset();
        i_m_arvalid        = 3'b001;
        i_m_araddr[31:0]   = 32'h2000;
        i_arready          = 1'b1;
        i_m_awvalid        = 3'b010;
        i_m_awaddr[63:32]  = 32'h1000;
        i_m_wdata[63:32]   = 32'h1234_5678;
        i_m_wstrb[7:4]     = 4'hF;
        i_m_wvalid         = 3'b010;
        i_m_wlast          = 3'b010;
        i_awready          = 1'b1;
        i_wready           = 1'b1;
        tick();
        total++; if ({o_rd_grant, o_wr_grant} !== {3'b001, 3'b010}) begin bad++; $display("FAIL rw_grants: got %b/%b want 001/010", o_rd_grant, o_wr_grant); end
        total++; if (o_awaddr !== 32'h1000) begin bad++; $display("FAIL rw_awaddr: got %h want 1000", o_awaddr); end
        total++; if (o_araddr !== 32'h2000) begin bad++; $display("FAIL rw_araddr: got %h want 2000", o_araddr); end
        total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL rw_wvalid_aw: got %b want 0", o_wvalid); end
        tick();
        i_m_arvalid = '0;
        i_m_awvalid = '0;
        i_rvalid    = 1'b1;
        i_rlast     = 1'b1;
        i_rdata     = 32'h55;
        #1;
        total++; if (o_wvalid !== 1'b1) begin bad++; $display("FAIL rw_wvalid: got %b want 1", o_wvalid); end
        total++; if (o_wdata !== 32'h1234_5678) begin bad++; $display("FAIL rw_wdata: got %h want 12345678", o_wdata); end
        total++; if (o_wstrb !== 4'hF) begin bad++; $display("FAIL rw_wstrb: got %h want f", o_wstrb); end
        total++; if (o_m_wready !== 3'b010) begin bad++; $display("FAIL rw_m_wready: got %b want 010", o_m_wready); end
        total++; if (o_m_rvalid !== 3'b001) begin bad++; $display("FAIL rw_m_rvalid: got %b want 001", o_m_rvalid); end
        total++; if ({o_rd_grant, o_wr_grant} !== {3'b001, 3'b010}) begin bad++; $display("FAIL rw_grants_data: got %b/%b want 001/010", o_rd_grant, o_wr_grant); end
        tick();
        i_m_wvalid = '0;
        i_m_wlast  = '0;
        i_rvalid   = 1'b0;
        i_rlast    = 1'b0;
        i_bvalid   = 1'b1;
        i_bid      = 4'h3;
        #1;
        total++; if (o_m_bvalid !== 3'b010) begin bad++; $display("FAIL rw_m_bvalid: got %b want 010", o_m_bvalid); end
        total++; if (o_rd_grant !== 3'b000) begin bad++; $display("FAIL rw_rd_done: got %b want 000", o_rd_grant); end
        total++; if (o_bready !== 1'b1) begin bad++; $display("FAIL rw_bready: got %b want 1", o_bready); end
        tick();
        i_bvalid = 1'b0;
        #1;
        total++; if (o_wr_grant !== 3'b000) begin bad++; $display("FAIL rw_wr_done: got %b want 000", o_wr_grant); end
        clear_inputs();
    endtask

    task automatic test_early_w;
        apply_reset();
        i_m_awaddr[63:32] = 32'h3000;
        i_m_awvalid       = 3'b010;
        i_m_wvalid        = 3'b010;
        i_m_wlast         = 3'b010;
        i_m_wdata[63:32]  = 32'hCAFE;
        i_m_wstrb[7:4]    = 4'hF;
        i_wready          = 1'b1;
        #1;
        total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL ew_idle_wvalid: got %b want 0", o_wvalid); end
        tick();
        total++; if (o_awvalid !== 1'b1) begin bad++; $display("FAIL ew_awvalid: got %b want 1", o_awvalid); end
        total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL ew_aw_wvalid: got %b want 0", o_wvalid); end
        total++; if (o_m_wready !== 3'b000) begin bad++; $display("FAIL ew_aw_wready: got %b want 000", o_m_wready); end
        tick();
        total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL ew_aw2_wvalid: got %b want 0", o_wvalid); end
        i_awready = 1'b1;
        tick();
        i_m_awvalid = '0;
        i_awready   = 1'b0;
        #1;
        total++; if (o_wvalid !== 1'b1) begin bad++; $display("FAIL ew_wvalid: got %b want 1", o_wvalid); end
        total++; if (o_wdata !== 32'hCAFE) begin bad++; $display("FAIL ew_wdata: got %h want cafe", o_wdata); end
        total++; if (o_m_wready !== 3'b010) begin bad++; $display("FAIL ew_m_wready: got %b want 010", o_m_wready); end
        tick();
        i_m_wvalid = '0;
        i_m_wlast  = '0;
        i_bvalid   = 1'b1;
        i_bresp    = 2'b10;
        i_bid      = 4'h7;
        #1;
        total++; if (o_m_bresp !== 6'b00_10_00) begin bad++; $display("FAIL ew_m_bresp: got %b want 001000", o_m_bresp); end
        total++; if (o_m_bvalid !== 3'b010) begin bad++; $display("FAIL ew_m_bvalid: got %b want 010", o_m_bvalid); end
        total++; if (o_m_bid !== 12'h070) begin bad++; $display("FAIL ew_m_bid: got %h want 070", o_m_bid); end
        tick();
        i_bvalid = 1'b0;
        i_bresp  = 2'b00;
        #1;
        total++; if (o_wr_grant !== 3'b000) begin bad++; $display("FAIL ew_grant_end: got %b want 000", o_wr_grant); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst;
        apply_reset();
        run_single_read(3'b001);
        i_m_arvalid = 3'b010;
        i_m_arlen   = {8'd0, 8'd3, 8'd0};
        i_arready   = 1'b1;
        i_m_awvalid = 3'b100;
        tick();
        tick();
        i_m_arvalid = '0;
        for (int b = 0; b < 2; b++) begin
            i_rvalid = 1'b1;
            i_rdata  = 32'hB0 + 32'(b);
            tick();
        end
        i_rdata = 32'hB2;
        #1;
        total++; if (o_m_rvalid !== 3'b010) begin bad++; $display("FAIL rm_beat2: got %b want 010", o_m_rvalid); end
        total++; if (o_wr_grant !== 3'b100) begin bad++; $display("FAIL rm_wr_busy: got %b want 100", o_wr_grant); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        total++; if (o_m_rvalid !== 3'b000) begin bad++; $display("FAIL rm_rvalid: got %b want 000", o_m_rvalid); end
        total++; if (o_rd_grant !== 3'b000) begin bad++; $display("FAIL rm_rd_grant: got %b want 000", o_rd_grant); end
        total++; if (o_wr_grant !== 3'b000) begin bad++; $display("FAIL rm_wr_grant: got %b want 000", o_wr_grant); end
        total++; if (o_rready !== 1'b0) begin bad++; $display("FAIL rm_rready: got %b want 0", o_rready); end
        total++; if (o_awvalid !== 1'b0) begin bad++; $display("FAIL rm_awvalid: got %b want 0", o_awvalid); end
        i_rvalid    = 1'b0;
        i_m_awvalid = '0;
        i_m_arlen   = '0;
        i_m_arvalid = 3'b011;
        tick();
        total++; if (o_rd_grant !== 3'b001) begin bad++; $display("FAIL rm_ptr_zero: got %b want 001", o_rd_grant); end
        tick();
        i_m_arvalid = 3'b010;
        i_rvalid    = 1'b1;
        i_rlast     = 1'b1;
        tick();
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        tick();
        total++; if (o_rd_grant !== 3'b010) begin bad++; $display("FAIL rm_fresh_grant: got %b want 010", o_rd_grant); end
        clear_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_rr_order();
        test_burst();
        test_concurrent_rw();
        test_early_w();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
